// File: rtl/multi_floor_movement.sv
// rtl/multi_floor_movement.sv - N-floor SCAN elevator movement controller (optional EMERGENCY_STOP_EN freeze)
module multi_floor_movement #(
    parameter int FLOORS       = 8,
    parameter int TRAVEL_TICKS = 4,
    parameter int DOOR_TICKS   = 3,
    parameter int FW           = $clog2(FLOORS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              My_Clock,
    input  logic [FLOORS-1:0] interior_panel,
    input  logic [FLOORS-1:0] exterior_panel,
`ifdef EMERGENCY_STOP_EN
    input  logic              emergency_stop,
`endif
    output logic [1:0]        engine,
    output logic [FLOORS-1:0] doors,
    output logic [FW-1:0]     current_floor,
    output logic [FLOORS-1:0] pending
);

    localparam int TW = $clog2(TRAVEL_TICKS + 1);
    localparam int DW = $clog2(DOOR_TICKS + 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    state_t            state, state_d;
    logic              dir_up, dir_d;
    logic [TW-1:0]     travel_cnt, travel_d;
    logic [DW-1:0]     door_cnt, door_d;
    logic              my_clock_q;
    logic              tick;
    logic              frozen;
    logic [FW-1:0]     floor_d;
    logic [FLOORS-1:0] calls;
    logic [FLOORS-1:0] clear_mask;
    logic [FLOORS-1:0] pending_d;
    logic [FLOORS-1:0] doors_d;
    logic [1:0]        engine_d;
    logic [2:0]        ev;

    assign tick  = My_Clock & ~my_clock_q;
    assign calls = interior_panel | exterior_panel;

`ifdef EMERGENCY_STOP_EN
    assign frozen = emergency_stop;
`else
    assign frozen = 1'b0;
`endif

    // SCAN decision from floor f: serve here, keep direction, reverse, or idle; returns {state, dir}
    function automatic logic [2:0] scan_eval(input logic [FW-1:0] f, input logic d,
                                             input logic [FLOORS-1:0] p);
        logic   above;
        logic   below;
        state_t s;
        logic   nd;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (i > int'(f))) above = 1'b1;
            if (p[i] && (i < int'(f))) below = 1'b1;
        end
        s  = IDLE;
        nd = d;
        if (p[f])               s = DOOR_OPEN;
        else if (d && above)    s = MOVE_UP;
        else if (!d && below)   s = MOVE_DOWN;
        else if (d && below)    begin s = MOVE_DOWN; nd = 1'b0; end
        else if (!d && above)   begin s = MOVE_UP;   nd = 1'b1; end
        return {s, nd};
    endfunction

    // next-state, counters, floor step, call latching and registered-output values
    always_comb begin
        state_d    = state;
        dir_d      = dir_up;
        floor_d    = current_floor;
        travel_d   = travel_cnt;
        door_d     = door_cnt;
        ev         = '0;
        clear_mask = '0;
        if (!frozen) begin
            case (state)
                IDLE: begin
                    ev      = scan_eval(current_floor, dir_up, pending);
                    state_d = state_t'(ev[2:1]);
                    dir_d   = ev[0];
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (tick) begin
                        if (travel_cnt == TW'(TRAVEL_TICKS - 1)) begin
                            travel_d = '0;
                            floor_d  = (state == MOVE_UP) ? current_floor + FW'(1)
                                                          : current_floor - FW'(1);
                            ev       = scan_eval(floor_d, dir_up, pending);
                            state_d  = state_t'(ev[2:1]);
                            dir_d    = ev[0];
                        end else begin
                            travel_d = travel_cnt + TW'(1);
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (calls[current_floor]) begin
                        door_d = '0;
                    end else if (tick) begin
                        if (door_cnt == DW'(DOOR_TICKS - 1)) begin
                            door_d  = '0;
                            ev      = scan_eval(current_floor, dir_up, pending);
                            state_d = state_t'(ev[2:1]);
                            dir_d   = ev[0];
                        end else begin
                            door_d = door_cnt + DW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            if (state_d != state) begin
                travel_d = '0;
                door_d   = '0;
            end
            if (state_d == DOOR_OPEN) clear_mask = FLOORS'(1) << floor_d;
        end
        pending_d = (pending | calls) & ~clear_mask;
        engine_d  = 2'b00;
        doors_d   = '0;
        if (!frozen) begin
            if (state_d == MOVE_UP)   engine_d = 2'b01;
            if (state_d == MOVE_DOWN) engine_d = 2'b10;
            if (state_d == DOOR_OPEN) doors_d  = FLOORS'(1) << floor_d;
        end
    end

    // state, counters and all outputs registered with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            dir_up        <= 1'b1;
            travel_cnt    <= '0;
            door_cnt      <= '0;
            my_clock_q    <= 1'b0;
            current_floor <= '0;
            pending       <= '0;
            engine        <= 2'b00;
            doors         <= '0;
        end else begin
            state         <= state_d;
            dir_up        <= dir_d;
            travel_cnt    <= travel_d;
            door_cnt      <= door_d;
            my_clock_q    <= My_Clock;
            current_floor <= floor_d;
            pending       <= pending_d;
            engine        <= engine_d;
            doors         <= doors_d;
        end
    end

endmodule
